// File: rtl/sat_pkg.sv
// Shared types and helpers for the 3SAT search controller and the PLA-side flip logic.
package sat_pkg;

  localparam int unsigned RAND_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StEval,
    StDone
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flip_select.sv
// Maps a random word to a one-hot mask over N variables. The low IW bits are at most 2N-1,
// so one conditional subtraction of N folds them into range.
module flip_select
  import sat_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [RAND_W-1:0] rand_i,
  output logic [N-1:0]      mask_o
);

  localparam int unsigned IW = (clog2(N) > 1) ? clog2(N) : 1;

  logic [IW-1:0] raw;
  int unsigned   idx;
  logic          unused_rand;

  assign unused_rand = ^rand_i[RAND_W-1:IW];

  always_comb begin
    raw = rand_i[IW-1:0];
    idx = 32'(raw);
    if (idx >= N) idx = idx - N;
  end

  for (genvar g = 0; g < N; g++) begin : g_mask
    assign mask_o[g] = (idx == g);
  end

endmodule

// File: rtl/sat_search_ctrl.sv
// WalkSAT-style sequencer: loads random assignments into the PLA, waits for its verdict
// and flips one random variable per decision until satisfied or out of flips and tries.
module sat_search_ctrl
  import sat_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned MAX_FLIPS = 8,
  parameter int unsigned MAX_TRIES = 16,
  parameter int unsigned EVAL_LAT  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [RAND_W-1:0]               rand_in,
  input  logic                            sat_in,
  output logic [N-1:0]                    assign_out,
  output logic [N-1:0]                    flip_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic [N-1:0]                    solution,
  output logic [clog2(MAX_TRIES+1)-1:0]   tries_used
);

  localparam int unsigned FW = clog2(MAX_FLIPS + 1);
  localparam int unsigned TW = clog2(MAX_TRIES + 1);
  localparam int unsigned WW = (clog2(EVAL_LAT + 1) > 1) ? clog2(EVAL_LAT + 1) : 1;

  localparam logic [FW-1:0] FlipsMax = FW'(MAX_FLIPS);
  localparam logic [TW-1:0] TriesMax = TW'(MAX_TRIES);
  localparam logic [WW-1:0] WaitInit = WW'(EVAL_LAT);

  state_e        state_q, state_d;
  logic [N-1:0]  assign_q, assign_d;
  logic [N-1:0]  flip_mask_q, flip_mask_d;
  logic          found_q, found_d;
  logic [N-1:0]  solution_q, solution_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [FW-1:0] flips_q, flips_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [N-1:0]  flip_sel;

  flip_select #(
    .N(N)
  ) u_flip_select (
    .rand_i(rand_in),
    .mask_o(flip_sel)
  );

  always_comb begin
    state_d     = state_q;
    assign_d    = assign_q;
    flip_mask_d = '0;
    found_d     = found_q;
    solution_d  = solution_q;
    tries_d     = tries_q;
    flips_d     = flips_q;
    wait_d      = wait_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          tries_d = '0;
        end
      end
      StLoad: begin
        assign_d = rand_in[N-1:0];
        flips_d  = '0;
        tries_d  = tries_q + TW'(1);
        wait_d   = WaitInit;
        state_d  = StEval;
      end
      StEval: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end else if (sat_in) begin
          state_d    = StDone;
          found_d    = 1'b1;
          solution_d = assign_q;
        end else if (flips_q == FlipsMax && tries_q == TriesMax) begin
          state_d    = StDone;
          found_d    = 1'b0;
          solution_d = '0;
        end else if (flips_q == FlipsMax) begin
          state_d = StLoad;
        end else begin
          flip_mask_d = flip_sel;
          assign_d    = assign_q ^ flip_sel;
          flips_d     = flips_q + FW'(1);
          wait_d      = WaitInit;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a simultaneous start.
    if (abort) begin
      state_d     = StIdle;
      found_d     = 1'b0;
      flip_mask_d = '0;
      tries_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      assign_q    <= '0;
      flip_mask_q <= '0;
      found_q     <= 1'b0;
      solution_q  <= '0;
      tries_q     <= '0;
      flips_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      assign_q    <= assign_d;
      flip_mask_q <= flip_mask_d;
      found_q     <= found_d;
      solution_q  <= solution_d;
      tries_q     <= tries_d;
      flips_q     <= flips_d;
      wait_q      <= wait_d;
    end
  end

  assign assign_out = assign_q;
  assign flip_mask  = flip_mask_q;
  assign busy       = (state_q == StLoad) || (state_q == StEval);
  assign done       = (state_q == StDone);
  assign found      = found_q;
  assign solution   = solution_q;
  assign tries_used = tries_q;

endmodule
